imdct_bram_arbiter: RTL

IMDCT_BRAM_ARBITER -- requirements
Module: imdct_bram_arbiter

---
 rtl/imdct_pkg.sv | 25 ++
 rtl/imdct_rr_pick.sv | 22 ++
 rtl/imdct_bram_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/imdct_pkg.sv
// Shared definitions for the IMDCT BRAM arbiter slice.
//   - default data/address widths and lock depth
//   - arbiter state enum (IDLE / OWN0 / OWN1)
//   - requester index constants (loader = 0, core = 1)
//   - onehot(): requester index -> 2-bit one-hot grant
package imdct_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned MAX_LOCK_DEF = 18;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_CORE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/imdct_rr_pick.sv
// 2-way round-robin selector.
// Ports:
//   req  [1:0] in  : request per requester
//   last       in  : index of the requester granted most recently
//   gnt  [1:0] out : one-hot grant (zero when nobody requests)
// On contention the requester that was not granted last wins.
module imdct_rr_pick
  import imdct_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = onehot(~last);
    end
  end

endmodule

// File: rtl/imdct_bram_arbiter.sv
// Two-requester arbiter for a single BRAM port (0 = AXI-lite loader,
// 1 = IMDCT core).
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   rq_req/rq_lock [1:0]         : per-requester request / keep-grant request
//   rq_addr0/1, rq_wdata0/1,
//   rq_we0/1                     : per-requester access (we == 0 means read)
//   rq_gnt [1:0]                 : combinational one-hot grant
//   rq_rvalid [1:0], rq_rdata    : read return, one cycle after a granted read
//   s_en/addr/din/we/dout_bram   : the shared BRAM port
// Build option: define IMDCT_BRAM_ARB_LOCK_EN to enable grant locking
// (OWN0/OWN1 states with a MAX_LOCK bound). Without it rq_lock is ignored
// and arbitration is plain per-cycle round-robin.
module imdct_bram_arbiter
  import imdct_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        rq_req,
  input  logic [1:0]        rq_lock,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [WIDTH-1:0]  rq_wdata0,
  input  logic [WIDTH-1:0]  rq_wdata1,
  input  logic [3:0]        rq_we0,
  input  logic [3:0]        rq_we1,
  output logic [1:0]        rq_gnt,
  output logic [1:0]        rq_rvalid,
  output logic [WIDTH-1:0]  rq_rdata,
  output logic              s_en_bram,
  output logic [ADDR_W-1:0] s_addr_bram,
  output logic [WIDTH-1:0]  s_din_bram,
  output logic [3:0]        s_we_bram,
  input  logic [WIDTH-1:0]  s_dout_bram
);

  logic       last_q;
  logic [1:0] rv_q;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic [1:0] rd_gnt;

  imdct_rr_pick u_pick (
    .req  (rq_req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

`ifdef IMDCT_BRAM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             owner_active;
  logic             owner_idx;

  always_comb begin
    owner_active = (state_q != IDLE);
    owner_idx    = (state_q == OWN1);
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    gnt          = '0;
    if (!reset) begin
      // A present owner keeps the port; an absent owner yields to plain RR.
      gnt = (owner_active && rq_req[owner_idx]) ? onehot(owner_idx) : rr_gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= REQ_CORE;
      rv_q    <= '0;
    end else begin
      rv_q <= rd_gnt;
      if (|gnt) begin
        last_q <= gnt[1];
      end
      if (state_q == IDLE) begin
        if ((|gnt) && rq_lock[gnt[1]]) begin
          // The entering grant already counts as the first locked grant.
          if ((CNT_MAX <= CNT_W'(1)) && rq_req[~gnt[1]]) begin
            cnt_q <= '0;
          end else begin
            state_q <= gnt[1] ? OWN1 : OWN0;
            cnt_q   <= CNT_W'(1);
          end
        end
      end else begin
        if (!rq_req[owner_idx] || !rq_lock[owner_idx] ||
            ((cnt_inc >= CNT_MAX) && rq_req[~owner_idx])) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^rq_lock;

  always_comb begin
    gnt = '0;
    if (!reset) begin
      gnt = rr_gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= REQ_CORE;
      rv_q   <= '0;
    end else begin
      rv_q <= rd_gnt;
      if (|gnt) begin
        last_q <= gnt[1];
      end
    end
  end
`endif

  always_comb begin
    rd_gnt      = {gnt[1] && (rq_we1 == 4'h0), gnt[0] && (rq_we0 == 4'h0)};
    s_en_bram   = |gnt;
    s_addr_bram = '0;
    s_din_bram  = '0;
    s_we_bram   = '0;
    if (gnt[1]) begin
      s_addr_bram = rq_addr1;
      s_din_bram  = rq_wdata1;
      s_we_bram   = rq_we1;
    end else if (gnt[0]) begin
      s_addr_bram = rq_addr0;
      s_din_bram  = rq_wdata0;
      s_we_bram   = rq_we0;
    end
  end

  assign rq_gnt    = gnt;
  // Masked during reset so a read returning in the reset cycle is dropped.
  assign rq_rvalid = reset ? 2'b00 : rv_q;
  assign rq_rdata  = s_dout_bram;

endmodule
